// File: rtl/clk_freq_meter_if.sv
// Control/result bundle for clk_freq_meter.
// cnt_min/cnt_max exist only when MEAS_MINMAX_EN is defined.
interface clk_freq_meter_if #(
  parameter int CNT_W = 32
) ();
  logic             start;
  logic             continuous;
  logic             busy;
  logic [CNT_W-1:0] count_out;
  logic             valid;
  logic             overflow;
`ifdef MEAS_MINMAX_EN
  logic [CNT_W-1:0] cnt_min;
  logic [CNT_W-1:0] cnt_max;

  modport master (output start, continuous,
                  input  busy, count_out, valid, overflow, cnt_min, cnt_max);
  modport slave  (input  start, continuous,
                  output busy, count_out, valid, overflow, cnt_min, cnt_max);
`else
  modport master (output start, continuous,
                  input  busy, count_out, valid, overflow);
  modport slave  (input  start, continuous,
                  output busy, count_out, valid, overflow);
`endif
endinterface

// File: rtl/clk_freq_meter.sv
// Gated frequency meter: counts sig_in rising edges over GATE_CYCLES clk_in cycles.
// Define MEAS_MINMAX_EN to add running cnt_min/cnt_max of the reported counts.
module clk_freq_meter #(
  parameter int GATE_CYCLES = 1_000_000,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_in,
  input  logic            rst_n,
  input  logic            sig_in,
  clk_freq_meter_if.slave meas
);

  localparam int               GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {IDLE = 1'b0, GATE = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   prev_p1;
  logic                   rise_p1;
  logic [GW-1:0]          gate_cnt;
  logic [CNT_W-1:0]       edge_cnt;
  logic [CNT_W-1:0]       edge_nxt;
  logic                   sat;
  logic                   sat_nxt;
  logic                   launch;
  logic                   win_end;
  logic                   restart;
  logic                   busy_c;
  logic                   valid_r;
  logic                   ovf_r;
  logic [CNT_W-1:0]       count_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != CNT_MAX)) return v + 1'b1;
    return v;
  endfunction

  // Stage p0: synchronizer chain; stage p1: previous synchronized value for edge detect
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      prev_p1 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], sig_in};
      prev_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign rise_p1  = sync_p0[SYNC_STAGES-1] & ~prev_p1;
  assign launch   = (state == IDLE) && (meas.start || meas.continuous);
  assign win_end  = (state == GATE) && (gate_cnt == GATE_LAST);
  assign restart  = launch || (win_end && meas.continuous);
  assign edge_nxt = sat_inc(edge_cnt, rise_p1);
  assign sat_nxt  = sat || (edge_nxt == CNT_MAX);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = GATE;
      GATE:    if (win_end && !meas.continuous) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_c = 1'b0;
    if (state == GATE) busy_c = 1'b1;
  end

  // Window counters are always cleared on window entry, so they need no reset
  always_ff @(posedge clk_in) begin
    if (restart) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
    end else if (state == GATE) begin
      gate_cnt <= gate_cnt + 1'b1;
      edge_cnt <= edge_nxt;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)              sat <= 1'b0;
    else if (restart)        sat <= 1'b0;
    else if (state == GATE)  sat <= sat_nxt;
  end

  // Result stage: includes a rise that lands in the last gate cycle
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      count_r <= '0;
      ovf_r   <= 1'b0;
    end else begin
      valid_r <= win_end;
      if (win_end) begin
        count_r <= edge_nxt;
        ovf_r   <= sat_nxt;
      end
    end
  end

  assign meas.busy      = busy_c;
  assign meas.valid     = valid_r;
  assign meas.count_out = count_r;
  assign meas.overflow  = ovf_r;

`ifdef MEAS_MINMAX_EN
  logic             first;
  logic [CNT_W-1:0] min_r;
  logic [CNT_W-1:0] max_r;

  // A start from IDLE re-arms tracking so the next result seeds both extremes
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      first <= 1'b1;
      min_r <= '0;
      max_r <= '0;
    end else if (launch && meas.start) begin
      first <= 1'b1;
    end else if (win_end) begin
      first <= 1'b0;
      if (first || (edge_nxt < min_r)) min_r <= edge_nxt;
      if (first || (edge_nxt > max_r)) max_r <= edge_nxt;
    end
  end

  assign meas.cnt_min = min_r;
  assign meas.cnt_max = max_r;
`endif

endmodule

// File: tb/tb_clk_freq_meter.sv
// Bench for clk_freq_meter: two instances (CNT_W=8 and CNT_W=4) share stimulus and are
// compared every cycle against a window/edge-count model; MEAS_MINMAX_EN adds min/max checks.
module tb_clk_freq_meter;
  localparam int N    = 100;
  localparam int SYNC = 2;
  localparam int HMAX = 20000;

  logic clk_in     = 1'b0;
  logic rst_n      = 1'b0;
  logic sig_in     = 1'b0;
  logic start      = 1'b0;
  logic continuous = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;
  int t_launch = 0;

  clk_freq_meter_if #(.CNT_W(8)) if8 ();
  clk_freq_meter_if #(.CNT_W(4)) if4 ();

  assign if8.start      = start;
  assign if8.continuous = continuous;
  assign if4.start      = start;
  assign if4.continuous = continuous;

  clk_freq_meter #(.GATE_CYCLES(N), .CNT_W(8), .SYNC_STAGES(SYNC)) dut8 (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .meas(if8));
  clk_freq_meter #(.GATE_CYCLES(N), .CNT_W(4), .SYNC_STAGES(SYNC)) dut4 (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .meas(if4));

  initial forever #5 clk_in = ~clk_in;
  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Reference model: sig_in samples per clock edge; a window opened at edge L reports, at
  // edge L+N, the number of sampled 0->1 transitions seen SYNC edges late in edges L+1..L+N.
  bit s_hist [HMAX];
  int j_edge;
  bit m_busy;
  int m_l;
  bit m_first;
  bit e_busy;
  bit e_valid;
  int e_cnt [2];
  bit e_ovf [2];
`ifdef MEAS_MINMAX_EN
  int e_min [2];
  int e_max [2];
`endif

  function automatic int rise_at(input int j);
    bit a;
    bit b;
    a = (j - SYNC >= 0) ? s_hist[j - SYNC] : 1'b0;
    b = (j - SYNC - 1 >= 0) ? s_hist[j - SYNC - 1] : 1'b0;
    return (a && !b) ? 1 : 0;
  endfunction

  initial forever begin
    int raw;
    int c;
    int cmax;
    @(posedge clk_in or negedge rst_n);
    if (!rst_n) begin
      j_edge = 0; m_busy = 1'b0; m_first = 1'b1; e_busy = 1'b0; e_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
        e_cnt[k] = 0; e_ovf[k] = 1'b0;
`ifdef MEAS_MINMAX_EN
        e_min[k] = 0; e_max[k] = 0;
`endif
      end
    end else begin
      if (j_edge >= HMAX) begin
        $display("FAIL model_history: got %0d edges, limit %0d", j_edge, HMAX);
        $fatal(1);
      end
      s_hist[j_edge] = sig_in;
      e_valid = 1'b0;
      if (m_busy) begin
        if (j_edge == m_l + N) begin
          raw = 0;
          for (int i = m_l + 1; i <= j_edge; i++) raw += rise_at(i);
          for (int k = 0; k < 2; k++) begin
            cmax = (k == 0) ? 255 : 15;
            c = (raw < cmax) ? raw : cmax;
            e_cnt[k] = c;
            e_ovf[k] = (raw >= cmax);
`ifdef MEAS_MINMAX_EN
            if (m_first) begin
              e_min[k] = c; e_max[k] = c;
            end else begin
              if (c < e_min[k]) e_min[k] = c;
              if (c > e_max[k]) e_max[k] = c;
            end
`endif
          end
          m_first = 1'b0;
          e_valid = 1'b1;
          if (continuous) m_l = j_edge;
          else            m_busy = 1'b0;
        end
      end else if (start || continuous) begin
        m_busy = 1'b1;
        m_l = j_edge;
        if (start) m_first = 1'b1;
      end
      e_busy = m_busy;
      j_edge++;
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk_in);
    if (chk_en) begin
      check("busy8",  {31'd0, if8.busy},     {31'd0, e_busy});
      check("valid8", {31'd0, if8.valid},    {31'd0, e_valid});
      check("count8", {24'd0, if8.count_out}, e_cnt[0]);
      check("ovf8",   {31'd0, if8.overflow}, {31'd0, e_ovf[0]});
      check("busy4",  {31'd0, if4.busy},     {31'd0, e_busy});
      check("valid4", {31'd0, if4.valid},    {31'd0, e_valid});
      check("count4", {28'd0, if4.count_out}, e_cnt[1]);
      check("ovf4",   {31'd0, if4.overflow}, {31'd0, e_ovf[1]});
`ifdef MEAS_MINMAX_EN
      check("min8", {24'd0, if8.cnt_min}, e_min[0]);
      check("max8", {24'd0, if8.cnt_max}, e_max[0]);
      check("min4", {28'd0, if4.cnt_min}, e_min[1]);
      check("max4", {28'd0, if4.cnt_max}, e_max[1]);
`endif
    end
  end

  // Valid-pulse log used by the literal scenario checks
  int v8_n = 0;
  int v8_cyc [$];
  int v8_cnt [$];
  int v8_ovf [$];
  int v4_cnt [$];
  int v4_ovf [$];
  initial forever begin
    @(negedge clk_in);
    if (if8.valid === 1'b1) begin
      v8_n++;
      v8_cyc.push_back(cyc);
      v8_cnt.push_back(int'(if8.count_out));
      v8_ovf.push_back(int'(if8.overflow));
    end
    if (if4.valid === 1'b1) begin
      v4_cnt.push_back(int'(if4.count_out));
      v4_ovf.push_back(int'(if4.overflow));
    end
  end

  // Block b of N samples uses period p_b: low for the first half, high for the second.
  task automatic drive_windows(input int nwin, input int p0, input int p1, input int p2,
                               input bit cont, input int extra);
    int per;
    int b;
    for (int it = 0; it < nwin * N + 2; it++) begin
      tick();
      b = it / N;
      per = (b == 0) ? p0 : (b == 1) ? p1 : p2;
      if (per > 0 && b < nwin) sig_in = ((it % N) % per) >= (per / 2);
      else                     sig_in = 1'b0;
      start      = (it == 1) || (it == extra);
      continuous = cont && (it >= 1) && (it <= (nwin - 1) * N + 1);
      if (it == 1) t_launch = cyc + 1;
      if (cont && it > 2 && it <= (nwin - 1) * N + 2) check("cont_busy", {31'd0, if8.busy}, 1);
    end
    sig_in = 1'b0; start = 1'b0; continuous = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int n0;
    int sz;
    int dens;
    repeat (3) @(posedge clk_in);
    #1;
    chk_en = 1'b1;
    check("rst_busy",  {31'd0, if8.busy}, 0);
    check("rst_count", {24'd0, if8.count_out}, 0);
    check("rst_valid", {31'd0, if8.valid}, 0);
    check("rst_ovf",   {31'd0, if8.overflow}, 0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();

    // sig_in held low, then held high
    n0 = v8_n;
    drive_windows(1, 0, 0, 0, 1'b0, -1);
    check("low_nvalid", v8_n - n0, 1);
    check("low_count", v8_cnt[v8_cnt.size()-1], 0);
    n0 = v8_n;
    sig_in = 1'b1;
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (N + 5) tick();
    sig_in = 1'b0;
    repeat (5) tick();
    check("high_nvalid", v8_n - n0, 1);
    check("high_count", v8_cnt[v8_cnt.size()-1], 0);

    // Toggle every 5 cycles, single start
    n0 = v8_n;
    drive_windows(1, 10, 0, 0, 1'b0, -1);
    check("p10_nvalid", v8_n - n0, 1);
    check("p10_count", v8_cnt[v8_cnt.size()-1], 10);
    check("p10_ovf", v8_ovf[v8_ovf.size()-1], 0);
    check("p10_busy_after", {31'd0, if8.busy}, 0);

    // Reset at gate cycle 50 aborts the window
    n0 = v8_n;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (50) tick();
    rst_n = 1'b0;
    #1;
    check("abort_count", {24'd0, if8.count_out}, 0);
    check("abort_busy",  {31'd0, if8.busy}, 0);
    check("abort_valid", {31'd0, if8.valid}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (N + 10) tick();
    check("abort_nvalid", v8_n - n0, 0);

    // Start at gate cycle 30 is ignored
    n0 = v8_n;
    drive_windows(1, 10, 0, 0, 1'b0, 31);
    check("midstart_nvalid", v8_n - n0, 1);
    check("midstart_latency", v8_cyc[v8_cyc.size()-1] - t_launch, N);
    check("midstart_count", v8_cnt[v8_cnt.size()-1], 10);

    // Continuous, period 4, three windows
    n0 = v8_n;
    drive_windows(3, 4, 4, 4, 1'b1, -1);
    sz = v8_cnt.size();
    check("cont_nvalid", v8_n - n0, 3);
    check("cont_first_latency", v8_cyc[sz-3] - t_launch, N);
    check("cont_gap1", v8_cyc[sz-2] - v8_cyc[sz-3], N);
    check("cont_gap2", v8_cyc[sz-1] - v8_cyc[sz-2], N);
    for (int k = 1; k <= 3; k++) check("cont_count", v8_cnt[sz-k], 25);

    // Saturation on the 4-bit instance, then a quiet window clears it
    drive_windows(2, 4, 0, 0, 1'b1, -1);
    sz = v4_cnt.size();
    check("sat4_count", v4_cnt[sz-2], 15);
    check("sat4_ovf", v4_ovf[sz-2], 1);
    check("sat4_clear_count", v4_cnt[sz-1], 0);
    check("sat4_clear_ovf", v4_ovf[sz-1], 0);
    check("sat8_count", v8_cnt[v8_cnt.size()-2], 25);

`ifdef MEAS_MINMAX_EN
    drive_windows(3, 10, 5, 20, 1'b1, -1);
    check("mm_min8", {24'd0, if8.cnt_min}, 5);
    check("mm_max8", {24'd0, if8.cnt_max}, 20);
    check("mm_max4", {28'd0, if4.cnt_max}, 15);
`endif

    // Randomized traffic: varying edge density, random starts, continuous and resets
    dens = 3;
    for (int r = 0; r < 5000; r++) begin
      tick();
      if (r % 400 == 0) dens = $urandom_range(0, 8);
      if ($urandom_range(0, dens) == 0) sig_in = ~sig_in;
      start = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 249) == 0) continuous = ~continuous;
      if ($urandom_range(0, 1499) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        rst_n = 1'b1;
      end
    end
    start = 1'b0;
    continuous = 1'b0;
    sig_in = 1'b0;
    repeat (2 * N + 10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
